// File: rtl/multi_cycle_control.sv
// Multicycle control unit: steps each instruction through IF/ID/EXE/MEM/WB.
// It issues a single PC write pulse in the last state of the instruction.
// The state register is the only storage. Every other output is decoded
// combinationally from the state, the opcode and the zero flag.
module multi_cycle_control (
  input  logic       clk,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       RegWre,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t     state_reg, state_next;
  logic       pc_wre_raw, ir_wre_raw, reg_wre_raw, mrd_raw, mwr_raw;
  logic [1:0] pc_src_raw;
  logic       is_rtype, is_alu, is_defined;

  // Group opcodes into the instruction classes the sequencer needs.
  always_comb begin
    is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR) ||
               (opcode == OP_AND) || (opcode == OP_SLL) || (opcode == OP_SLT);
    is_alu   = is_rtype || (opcode == OP_ADDI) || (opcode == OP_ORI);
    is_defined = is_alu || (opcode == OP_SW) || (opcode == OP_LW) ||
                 (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                 (opcode == OP_J) || (opcode == OP_HALT);
  end

  // Datapath select decode; it depends only on the opcode and so stays stable from ID on.
  always_comb begin
    RegDst    = is_rtype;
    ALUSrcA   = (opcode == OP_SLL);
    ALUSrcB   = (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                (opcode == OP_LW)   || (opcode == OP_SW);
    ExtSel    = (opcode != OP_ORI);
    DBDataSrc = (opcode == OP_LW);
    case (opcode)
      OP_SUB, OP_BEQ, OP_BNE: ALUOp = 3'b001;
      OP_SLL:                 ALUOp = 3'b010;
      OP_OR, OP_ORI:          ALUOp = 3'b011;
      OP_AND:                 ALUOp = 3'b100;
      OP_SLT:                 ALUOp = 3'b101;
      default:                ALUOp = 3'b000;
    endcase
  end

  // State register; reset drops straight back to IF.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_reg <= S_IF;
    else        state_reg <= state_next;
  end

  // Next state and raw enables for each step of the instruction.
  always_comb begin
    state_next  = state_reg;
    pc_wre_raw  = 1'b0;
    pc_src_raw  = 2'b00;
    ir_wre_raw  = 1'b0;
    reg_wre_raw = 1'b0;
    mrd_raw     = 1'b0;
    mwr_raw     = 1'b0;
    case (state_reg)
      S_IF: begin
        ir_wre_raw = 1'b1;
        state_next = S_ID;
      end
      S_ID: begin
        if (opcode == OP_J) begin
          pc_wre_raw = 1'b1;
          pc_src_raw = 2'b10;
          state_next = S_IF;
        end else if (opcode == OP_HALT) begin
          state_next = S_HALT;
        end else if (!is_defined) begin
          pc_wre_raw = 1'b1;       // unknown opcode behaves as a nop
          state_next = S_IF;
        end else begin
          state_next = S_EXE;
        end
      end
      S_EXE: begin
        if (opcode == OP_BEQ) begin
          pc_wre_raw = 1'b1;
          pc_src_raw = zero ? 2'b01 : 2'b00;
          state_next = S_IF;
        end else if (opcode == OP_BNE) begin
          pc_wre_raw = 1'b1;
          pc_src_raw = zero ? 2'b00 : 2'b01;
          state_next = S_IF;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          state_next = S_MEM;
        end else if (is_alu) begin
          state_next = S_WB;
        end else begin
          state_next = S_IF;
        end
      end
      S_MEM: begin
        if (opcode == OP_SW) begin
          mwr_raw    = 1'b1;
          pc_wre_raw = 1'b1;
          state_next = S_IF;
        end else if (opcode == OP_LW) begin
          mrd_raw    = 1'b1;
          state_next = S_WB;
        end else begin
          state_next = S_IF;
        end
      end
      S_WB: begin
        reg_wre_raw = 1'b1;
        pc_wre_raw  = 1'b1;
        state_next  = S_IF;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  // Enables are held low for as long as reset is asserted. PCSrc reads 00 whenever no PC write occurs.
  always_comb begin
    PCWre  = pc_wre_raw  & Reset;
    IRWre  = ir_wre_raw  & Reset;
    RegWre = reg_wre_raw & Reset;
    mRD    = mrd_raw     & Reset;
    mWR    = mwr_raw     & Reset;
    PCSrc  = PCWre ? pc_src_raw : 2'b00;
    state  = state_reg;
  end

endmodule
